// File: rtl/tsc_pkg.sv
// Shared TSC CPU definitions: datapath width, sequencer state encodings, reset PC.
package tsc_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [15:0] TSC_RESET_PC = 16'h0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_sequencer_timer.sv
// FETCH wait counter: counts cycles spent waiting for a memory word and flags
// the cycle in which the count would reach TIMEOUT.
module fetch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(TIMEOUT))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Asserted in the waiting cycle whose increment would hit TIMEOUT.
  assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// FETCH -> DECODE -> EXEC instruction sequencer for the TSC CPU: owns the PC,
// memory read handshake, instruction register and retired-instruction count.
module fetch_sequencer
  import tsc_pkg::*;
#(
  parameter int WORD_SIZE = tsc_pkg::WORD_SIZE,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inputReady,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic [WORD_SIZE-1:0] pc_next,
  input  logic                 halt,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] ir,
  output logic                 ir_valid,
  output logic                 exec_en,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 timeout_err,
  output logic [2:0]           state_o
);

  state_t                state_reg, state_next;
  logic                  input_ready_d_reg;
  logic [WORD_SIZE-1:0]  pc_reg;
  logic [WORD_SIZE-1:0]  ir_reg;
  logic [WORD_SIZE-1:0]  num_inst_reg;
  logic                  timeout_err_reg;

  logic rise;
  logic in_fetch;
  logic ir_load;
  logic timeout_set;
  logic expired;

  assign rise     = inputReady & ~input_ready_d_reg;
  assign in_fetch = (state_reg == FETCH);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~in_fetch),
    .enable  (in_fetch & ~rise),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A rising edge in the final waiting cycle beats the timeout.
  always_comb begin
    state_next  = state_reg;
    ir_load     = 1'b0;
    timeout_set = 1'b0;
    case (state_reg)
      IDLE:   state_next = FETCH;
      FETCH: begin
        if (rise) begin
          state_next = DECODE;
          ir_load    = 1'b1;
        end else if (expired) begin
          state_next  = HALTED;
          timeout_set = 1'b1;
        end
      end
      DECODE: state_next = EXEC;
      EXEC:   state_next = halt ? HALTED : FETCH;
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      input_ready_d_reg <= 1'b0;
      pc_reg            <= WORD_SIZE'(TSC_RESET_PC);
      ir_reg            <= '0;
      num_inst_reg      <= '0;
      timeout_err_reg   <= 1'b0;
    end else begin
      input_ready_d_reg <= inputReady;
      if (ir_load) begin
        ir_reg <= mem_data;
      end
      if (state_reg == EXEC) begin
        pc_reg       <= pc_next;
        num_inst_reg <= num_inst_reg + 1'b1;
      end
      if (timeout_set) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  // Strobes decode the state register only, so reset kills them immediately.
  assign readM       = (state_reg == FETCH);
  assign ir_valid    = (state_reg == DECODE) || (state_reg == EXEC);
  assign exec_en     = (state_reg == EXEC);
  assign address     = pc_reg;
  assign ir          = ir_reg;
  assign num_inst    = num_inst_reg;
  assign timeout_err = timeout_err_reg;
  assign state_o     = state_reg;

endmodule
